// File: rtl/obstacle_scheduler.sv
// Obstacle spawn/scroll scheduler: requests a width, spawns at the right edge, scrolls left, waits a gap.
// Optional OBS_PAUSE_EN: game_run=0 in RUN/GAP freezes the obstacle instead of aborting to IDLE.
//
// state | meaning
// IDLE  | waiting for game_run
// REQ   | rnd_req high, generator stepping
// CAPT  | rnd_width valid, capture and spawn
// RUN   | obstacle scrolling left on frame_tick
// GAP   | obstacle gone, counting frame_ticks before next request
module obstacle_scheduler #(
    parameter int SCREEN_W   = 1024,
    parameter int SPEED      = 4,
    parameter int WIDTH_MIN  = 230,
    parameter int WIDTH_MAX  = 690,
    parameter int GAP_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_run,
    input  logic        frame_tick,
    input  logic [15:0] rnd_width,
    output logic        rnd_req,
    output logic [15:0] obs_x,
    output logic [15:0] obs_w,
    output logic        obs_valid,
    output logic        spawn_pulse,
    output logic        range_err,
    output logic [7:0]  obs_count
);

`ifdef OBS_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ, CAPT, RUN, GAP} state_t;

    state_t        state, state_nx;
    logic [15:0]   gap_cnt, gap_cnt_nx;
    logic [15:0]   obs_x_nx, obs_w_nx;
    logic [7:0]    obs_count_nx;
    logic          rnd_req_nx, obs_valid_nx, spawn_nx, range_err_nx;
    logic          w_low, w_high, exit_now;
    logic [15:0]   x_next;
    logic [16:0]   x_edge;

    assign w_low  = rnd_width < 16'(WIDTH_MIN);
    assign w_high = rnd_width > 16'(WIDTH_MAX);
    assign x_next = obs_x - 16'(SPEED);
    // Right edge after the move, one bit wider so obs_w cannot overflow the sign.
    assign x_edge   = {x_next[15], x_next} + {1'b0, obs_w};
    assign exit_now = x_edge[16] || (x_edge == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            obs_x       <= '0;
            obs_w       <= '0;
            obs_count   <= '0;
            rnd_req     <= 1'b0;
            obs_valid   <= 1'b0;
            spawn_pulse <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            gap_cnt     <= gap_cnt_nx;
            obs_x       <= obs_x_nx;
            obs_w       <= obs_w_nx;
            obs_count   <= obs_count_nx;
            rnd_req     <= rnd_req_nx;
            obs_valid   <= obs_valid_nx;
            spawn_pulse <= spawn_nx;
            range_err   <= range_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        gap_cnt_nx   = gap_cnt;
        obs_x_nx     = obs_x;
        obs_w_nx     = obs_w;
        obs_count_nx = obs_count;
        rnd_req_nx   = 1'b0;
        obs_valid_nx = obs_valid;
        spawn_nx     = 1'b0;
        range_err_nx = 1'b0;

        if (!game_run) begin
            if (!(PAUSE_EN && (state == RUN || state == GAP))) begin
                state_nx     = IDLE;
                obs_valid_nx = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_nx   = REQ;
                    rnd_req_nx = 1'b1;
                end
                REQ: state_nx = CAPT;
                CAPT: begin
                    if (w_low)       obs_w_nx = 16'(WIDTH_MIN);
                    else if (w_high) obs_w_nx = 16'(WIDTH_MAX);
                    else             obs_w_nx = rnd_width;
                    range_err_nx = w_low | w_high;
                    obs_x_nx     = 16'(SCREEN_W);
                    obs_valid_nx = 1'b1;
                    spawn_nx     = 1'b1;
                    obs_count_nx = obs_count + 8'd1;
                    state_nx     = RUN;
                end
                RUN: begin
                    if (frame_tick) begin
                        if (exit_now) begin
                            obs_valid_nx = 1'b0;
                            gap_cnt_nx   = '0;
                            state_nx     = GAP;
                        end else begin
                            obs_x_nx = x_next;
                        end
                    end
                end
                GAP: begin
                    if (frame_tick) begin
                        gap_cnt_nx = gap_cnt + 16'd1;
                        if (gap_cnt == 16'(GAP_FRAMES - 1)) begin
                            state_nx   = REQ;
                            rnd_req_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: main instance with default parameters,
// second small instance for the obs_count wrap run.
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        reset, game_run, frame_tick;
    logic [15:0] rnd_width;
    logic        rnd_req, obs_valid, spawn_pulse, range_err;
    logic [15:0] obs_x, obs_w;
    logic [7:0]  obs_count;

    logic        game_run2, frame_tick2;
    logic [15:0] rnd_width2;
    logic        rnd_req2, obs_valid2, spawn_pulse2, range_err2;
    logic [15:0] obs_x2, obs_w2;
    logic [7:0]  obs_count2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .clk(clk), .reset(reset), .game_run(game_run), .frame_tick(frame_tick),
        .rnd_width(rnd_width), .rnd_req(rnd_req), .obs_x(obs_x), .obs_w(obs_w),
        .obs_valid(obs_valid), .spawn_pulse(spawn_pulse), .range_err(range_err),
        .obs_count(obs_count)
    );

    obstacle_scheduler #(
        .SCREEN_W(8), .SPEED(4), .WIDTH_MIN(4), .WIDTH_MAX(8), .GAP_FRAMES(1)
    ) dut_small (
        .clk(clk), .reset(reset), .game_run(game_run2), .frame_tick(frame_tick2),
        .rnd_width(rnd_width2), .rnd_req(rnd_req2), .obs_x(obs_x2), .obs_w(obs_w2),
        .obs_valid(obs_valid2), .spawn_pulse(spawn_pulse2), .range_err(range_err2),
        .obs_count(obs_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n, output int reqs);
        reqs = 0;
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            if (rnd_req) reqs++;
        end
        frame_tick = 1'b0;
    endtask

    task automatic hard_reset();
        game_run = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
    endtask

    // Precondition: state IDLE. Returns at the first negedge in RUN.
    task automatic start_spawn(input logic [15:0] w);
        rnd_width = w;
        game_run  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int r, spawns, reqs2, dbl;
        logic prev;
        reset = 1'b0; game_run = 1'b0; frame_tick = 1'b0; rnd_width = '0;
        game_run2 = 1'b0; frame_tick2 = 1'b1; rnd_width2 = '0;
        repeat (2) @(negedge clk);

        chk("rst_rnd_req", rnd_req, 0);
        chk("rst_obs_x", obs_x, 0);
        chk("rst_obs_w", obs_w, 0);
        chk("rst_obs_valid", obs_valid, 0);
        chk("rst_spawn", spawn_pulse, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_obs_count", obs_count, 0);

        // First spawn, width 230, then full scroll-out
        reset = 1'b1; game_run = 1'b1; rnd_width = 16'd230;
        @(negedge clk);
        chk("req_pulse", rnd_req, 1);
        @(negedge clk);
        chk("req_one_cycle", rnd_req, 0);
        chk("capt_not_valid", obs_valid, 0);
        @(negedge clk);
        chk("spawn_valid", obs_valid, 1);
        chk("spawn_x", obs_x, 1024);
        chk("spawn_w", obs_w, 230);
        chk("spawn_pulse", spawn_pulse, 1);
        chk("spawn_no_err", range_err, 0);
        chk("spawn_count", obs_count, 1);
        @(negedge clk);
        chk("spawn_pulse_drop", spawn_pulse, 0);

        ticks(313, r);
        chk("tick313_x", obs_x, 16'hFF1C);
        chk("tick313_valid", obs_valid, 1);
        ticks(1, r);
        chk("tick314_valid", obs_valid, 0);
        chk("tick314_x_hold", obs_x, 16'hFF1C);
        ticks(59, r);
        chk("gap59_no_req", r, 0);
        ticks(1, r);
        chk("gap60_req", rnd_req, 1);

        // Second spawn with width 0 -> clamped low
        rnd_width = 16'd0;
        @(negedge clk);
        chk("gap_req_one_cycle", rnd_req, 0);
        @(negedge clk);
        chk("w0_clamped", obs_w, 230);
        chk("w0_range_err", range_err, 1);
        chk("w0_count", obs_count, 2);
        @(negedge clk);
        chk("w0_range_err_drop", range_err, 0);
        ticks(3, r);
        chk("run_x_1012", obs_x, 1012);

        // Async reset mid-RUN, checked before the next clock edge
        #2 reset = 1'b0;
        #1;
        chk("async_valid", obs_valid, 0);
        chk("async_x", obs_x, 0);
        chk("async_w", obs_w, 0);
        chk("async_count", obs_count, 0);
        @(negedge clk);
        reset = 1'b1; rnd_width = 16'd700;
        @(negedge clk);
        chk("post_rst_req", rnd_req, 1);
        @(negedge clk);
        @(negedge clk);
        chk("w700_clamped", obs_w, 690);
        chk("w700_range_err", range_err, 1);
        chk("w700_count", obs_count, 1);

        hard_reset();
        start_spawn(16'd690);
        chk("w690_w", obs_w, 690);
        chk("w690_no_err", range_err, 0);
        chk("w690_spawn", spawn_pulse, 1);

        // Drop during CAPT discards the capture
        hard_reset();
        rnd_width = 16'd300; game_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        game_run = 1'b0;
        @(negedge clk);
        chk("abort_capt_valid", obs_valid, 0);
        chk("abort_capt_spawn", spawn_pulse, 0);
        chk("abort_capt_count", obs_count, 0);

        // Drop mid-RUN coincident with frame_tick
        start_spawn(16'd300);
        chk("abort_run_count", obs_count, 1);
        ticks(2, r);
        chk("abort_run_x_pre", obs_x, 1016);
        game_run = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("abort_run_x", obs_x, 1016);
        chk("abort_run_req", rnd_req, 0);
`ifdef OBS_PAUSE_EN
        chk("pause_valid", obs_valid, 1);
        game_run = 1'b1;
        ticks(1, r);
        chk("pause_resume_x", obs_x, 1012);
        chk("pause_resume_valid", obs_valid, 1);
`else
        chk("abort_run_valid", obs_valid, 0);
        game_run = 1'b1;
        @(negedge clk);
        chk("abort_rerun_req", rnd_req, 1);
        chk("abort_rerun_count", obs_count, 1);
`endif

        // Wrap run on the small instance
        game_run = 1'b0;
        hard_reset();
        game_run2 = 1'b1;
        spawns = 0; reqs2 = 0; dbl = 0; prev = 1'b0;
        for (int c = 0; c < 3000 && spawns < 256; c++) begin
            @(negedge clk);
            if (rnd_req2) reqs2++;
            if (rnd_req2 && prev) dbl++;
            prev = rnd_req2;
            if (spawn_pulse2) begin
                spawns++;
                if (spawns == 255) chk("count_255", obs_count2, 255);
            end
        end
        chk("wrap_spawns_in_budget", spawns, 256);
        chk("wrap_count", obs_count2, 0);
        chk("wrap_reqs", reqs2, 256);
        chk("wrap_no_double_req", dbl, 0);
        game_run2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
